// File: rtl/frame_scan_gen.sv
// Raster pixel-stream source: walks a fixed raster, reads RGB565 pixels from a
// double-banked frame buffer and emits x/y/pixel aligned on the same cycle.
//
// state | meaning
// IDLE  | no reads issued; raster parked at (0,0)
// RUN   | scanning, en held high
// DRAIN | en dropped; finishing the current frame before returning to IDLE
module frame_scan_gen #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 208,
  parameter int H_TOTAL  = 320,
  parameter int V_TOTAL  = 320,
  parameter int OFS_W    = 16,
  parameter int RD_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             ram_rd_en,
  output logic [OFS_W:0]   ram_addr,
  input  logic [15:0]      ram_rdata,
  output logic [10:0]      x_pos,
  output logic [10:0]      y_pos,
  output logic [15:0]      pix_data,
  output logic             pix_valid,
  output logic             frame_start
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [10:0]        h;
  logic [10:0]        v;
  logic [OFS_W-1:0]   offset;
  logic               bank;
  logic               pending;

  // Stage 0 is the issue stage (coincides with ram_rd_en); stage RD_LAT lines up with ram_rdata.
  logic [10:0]        x_d [RD_LAT+1];
  logic [10:0]        y_d [RD_LAT+1];
  logic [RD_LAT:0]    act_d;
  logic [RD_LAT:0]    fs_d;

  logic issue;
  logic h_end;
  logic v_end;
  logic frame_end;
  logic active;

  // A raster point is issued every clock while scanning, and on the IDLE->RUN edge itself.
  assign issue     = (state != IDLE) || en;
  assign h_end     = (h == 11'(H_TOTAL - 1));
  assign v_end     = (v == 11'(V_TOTAL - 1));
  assign frame_end = h_end && v_end;
  assign active    = (h < 11'(H_ACTIVE)) && (v < 11'(V_ACTIVE));

  // Sequencer: raster counters, read offset, bank swap handshake and run/drain control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      h        <= '0;
      v        <= '0;
      offset   <= '0;
      bank     <= 1'b0;
      pending  <= 1'b0;
      swap_ack <= 1'b0;
      ram_addr <= '0;
    end else begin
      swap_ack <= 1'b0;
      if (issue) begin
        if (active) begin
          ram_addr <= {bank, offset};
          offset   <= offset + 1'b1;
        end
        if (frame_end) begin
          h      <= '0;
          v      <= '0;
          offset <= '0;
          state  <= en ? RUN : IDLE;
          // a request arriving on the boundary cycle itself still makes this frame's swap
          if (pending || swap_req) begin
            bank     <= ~bank;
            pending  <= 1'b0;
            swap_ack <= 1'b1;
          end
        end else begin
          pending <= pending | swap_req;
          if (h_end) begin
            h <= '0;
            v <= v + 11'd1;
          end else begin
            h <= h + 11'd1;
          end
          case (state)
            IDLE:    state <= RUN;
            RUN:     if (!en) state <= DRAIN;
            default: state <= state;
          endcase
        end
      end else begin
        pending <= pending | swap_req;
      end
    end
  end

  // Position/active/frame-start delay line matching the RAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) begin
        x_d[i] <= 11'h7FF;
        y_d[i] <= 11'h7FF;
      end
      act_d <= '0;
      fs_d  <= '0;
    end else begin
      x_d[0]   <= issue ? h : 11'h7FF;
      y_d[0]   <= issue ? v : 11'h7FF;
      act_d[0] <= issue && active;
      fs_d[0]  <= issue && (h == 11'd0) && (v == 11'd0);
      for (int i = 1; i <= RD_LAT; i++) begin
        x_d[i]   <= x_d[i-1];
        y_d[i]   <= y_d[i-1];
        act_d[i] <= act_d[i-1];
        fs_d[i]  <= fs_d[i-1];
      end
    end
  end

  assign ram_rd_en   = act_d[0];
  assign x_pos       = x_d[RD_LAT];
  assign y_pos       = y_d[RD_LAT];
  assign pix_valid   = act_d[RD_LAT];
  assign frame_start = fs_d[RD_LAT];
  // Blanking forces all-ones so downstream dark-pixel counting never sees it.
  assign pix_data    = act_d[RD_LAT] ? ram_rdata : 16'hFFFF;

endmodule

// File: tb/tb_frame_scan_gen.sv
// Bench for frame_scan_gen on a reduced raster so whole frames fit in a short run.
module tb_frame_scan_gen;

  localparam int HA  = 12;
  localparam int VA  = 6;
  localparam int HT  = 16;
  localparam int VT  = 10;
  localparam int OW  = 16;
  localparam int LAT = 2;
  localparam int FT  = HT * VT;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          swap_req;
  logic          swap_ack;
  logic          ram_rd_en;
  logic [OW:0]   ram_addr;
  logic [15:0]   ram_rdata;
  logic [10:0]   x_pos;
  logic [10:0]   y_pos;
  logic [15:0]   pix_data;
  logic          pix_valid;
  logic          frame_start;

  frame_scan_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .OFS_W(OW), .RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .swap_req(swap_req), .swap_ack(swap_ack),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .x_pos(x_pos), .y_pos(y_pos), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Frame buffer contents: bank 0 holds the offset, bank 1 a scrambled offset.
  function automatic logic [15:0] ram_fn(input logic [OW:0] a);
    return a[OW] ? (a[15:0] ^ 16'h2AAA) : a[15:0];
  endfunction

  logic [OW:0] h_addr [LAT];
  logic        h_en   [LAT];
  always @(posedge clk) begin
    h_addr[0] <= ram_addr;
    h_en[0]   <= ram_rd_en;
    for (int i = 1; i < LAT; i++) begin
      h_addr[i] <= h_addr[i-1];
      h_en[i]   <= h_en[i-1];
    end
  end
  assign ram_rdata = (h_en[LAT-1] === 1'b1) ? ram_fn(h_addr[LAT-1]) : 16'hDEAD;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame position as a linear point index, bank choice per frame.
  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        fs;
    logic [15:0] d;
  } pix_t;

  pix_t        pq[$];
  int          m_n;
  bit          m_scan;
  bit          m_bank;
  bit          m_pend;
  logic        m_rd;
  logic        m_ack;
  logic [OW:0] m_addr;

  function automatic pix_t idle_pix();
    pix_t p;
    p.x = 11'h7FF; p.y = 11'h7FF; p.act = 1'b0; p.fs = 1'b0; p.d = 16'hFFFF;
    return p;
  endfunction

  task automatic model_step();
    pix_t p;
    int x, y, ofs;
    bit act;
    if (!rst) begin
      m_scan = 0; m_n = 0; m_bank = 0; m_pend = 0;
      m_rd = 1'b0; m_ack = 1'b0; m_addr = '0;
      pq.delete();
      for (int i = 0; i <= LAT; i++) pq.push_back(idle_pix());
    end else begin
      p = idle_pix();
      m_ack = 1'b0;
      m_rd  = 1'b0;
      if (m_scan || en) begin
        x   = m_n % HT;
        y   = m_n / HT;
        act = (x < HA) && (y < VA);
        ofs = y * HA + x;
        p.x = 11'(x); p.y = 11'(y); p.act = act; p.fs = (m_n == 0);
        if (act) begin
          m_addr = {m_bank, 16'(ofs)};
          m_rd   = 1'b1;
          p.d    = ram_fn(m_addr);
        end
        if (m_n == FT - 1) begin
          if (m_pend || swap_req) begin
            m_bank = !m_bank; m_pend = 0; m_ack = 1'b1;
          end
          m_n = 0;
          m_scan = en;
        end else begin
          m_pend = m_pend | swap_req;
          m_n++;
          m_scan = 1;
        end
      end else begin
        m_pend = m_pend | swap_req;
      end
      pq.push_back(p);
      void'(pq.pop_front());
    end
  endtask

  int  vcnt = 0;
  int  fcyc = 0;
  bit  full = 0;

  task automatic check_all();
    chk("ram_rd_en", ram_rd_en, m_rd);
    chk("ram_addr", ram_addr, m_addr);
    chk("swap_ack", swap_ack, m_ack);
    chk("x_pos", x_pos, pq[0].x);
    chk("y_pos", y_pos, pq[0].y);
    chk("pix_valid", pix_valid, pq[0].act);
    chk("frame_start", frame_start, pq[0].fs);
    chk("pix_data", pix_data, pq[0].d);
    if (frame_start === 1'b1) begin
      if (full && fcyc == FT) chk("valid_per_frame", vcnt, HA * VA);
      vcnt = 0; fcyc = 0; full = 1;
    end
    if (pix_valid === 1'b1) vcnt++;
    fcyc++;
  endtask

  task automatic cyc(input logic r, input logic e, input logic s);
    @(negedge clk);
    check_all();
    rst = r; en = e; swap_req = s;
    if (!r) full = 0;
    @(posedge clk);
    model_step();
  endtask

  task automatic run_until(input int target, input logic e);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3 * FT; i++) begin
      if (m_scan && m_n == target) begin
        hit = 1;
        break;
      end
      cyc(1'b1, e, 1'b0);
    end
    chk("wait_bound", hit, 1'b1);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; swap_req = 1'b0;
    @(posedge clk);
    model_step();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);   // swap requested while idle
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);   // start scanning
    run_until(20, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);   // absorbed: already pending
    run_until(40, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run_until(FT - 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    run_until(FT - 1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);   // request on the boundary cycle
    run_until(30, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run_until(50, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);   // second request in the same frame
    run_until(50 + FT / 2, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);   // drop en mid-frame: drain to end, then idle
    for (int i = 0; i < FT; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run_until(70, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    run_until(100, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);   // en back during drain: back-to-back frame
    run_until(FT / 2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);   // one-clock reset mid-frame
    for (int i = 0; i < 2 * FT; i++) cyc(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      logic r, e, s;
      r = ($urandom_range(0, 999) != 0);
      e = ($urandom_range(0, 59) == 0) ? !en : en;
      s = ($urandom_range(0, 29) == 0);
      cyc(r, e, s);
    end
    for (int i = 0; i < FT + LAT + 4; i++) cyc(1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
